// File: rtl/snd_cmd_queue_if.sv
// Command/NMI/IRQ signal bundle between the main-CPU strobe, the sound Z80 and snd_cmd_queue.
interface snd_cmd_queue_if #(
  parameter int CMD_W      = 8,
  parameter int DEPTH_LOG2 = 2
);
  logic [CMD_W-1:0]    sndno;
  logic                sndstart;
  logic                com_rd;
  logic                ovf_clr;
  logic                cpu_nmia;
  logic                cpu_irqa;
  logic                cpu_nmi;
  logic                cpu_irq;
  logic [CMD_W-1:0]    comlatch;
  logic [DEPTH_LOG2:0] fifo_count;
  logic                overflow;

  modport master (
    output sndno, sndstart, com_rd, ovf_clr, cpu_nmia, cpu_irqa,
    input  cpu_nmi, cpu_irq, comlatch, fifo_count, overflow
  );

  modport slave (
    input  sndno, sndstart, com_rd, ovf_clr, cpu_nmia, cpu_irqa,
    output cpu_nmi, cpu_irq, comlatch, fifo_count, overflow
  );
endinterface

// File: rtl/snd_cmd_queue.sv
// Sound command FIFO with per-command NMI, registered head latch, overflow flag
// and a free-running periodic IRQ timer for the sound CPU.
module snd_cmd_queue #(
  parameter int CMD_W        = 8,
  parameter int DEPTH_LOG2   = 2,
  parameter int TIMER_PERIOD = 33334,
  parameter int NMI_REARM    = 1
) (
  input  logic           clk8M,
  input  logic           reset,
  snd_cmd_queue_if.slave bus
);
  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int CNT_W = DEPTH_LOG2 + 1;
  localparam int TMR_W = $clog2(TIMER_PERIOD);

  logic [CMD_W-1:0]      r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic [CMD_W-1:0]      r_latch;
  logic                  r_start_d;
  logic                  r_rd_d;
  logic                  r_nmi;
  logic                  r_irq;
  logic                  r_ovf;
  logic [TMR_W-1:0]      r_tmr;

  logic                  w_push_req;
  logic                  w_pop_req;
  logic                  w_push_ok;
  logic                  w_pop_ok;
  logic                  w_drop;
  logic                  w_nmi_set;
  logic                  w_tmr_wrap;
  logic [DEPTH_LOG2-1:0] w_rd_nxt;
  logic [CNT_W-1:0]      w_count_nxt;
  logic [CMD_W-1:0]      w_latch_nxt;

  assign w_push_req = bus.sndstart & ~r_start_d;
  assign w_pop_req  = bus.com_rd & ~r_rd_d;
  assign w_pop_ok   = w_pop_req && (r_count != '0);
  // A full FIFO still accepts a push when a pop frees the head slot in the same cycle.
  assign w_push_ok  = w_push_req && ((r_count != CNT_W'(DEPTH)) || w_pop_ok);
  assign w_drop     = w_push_req && !w_push_ok;
  assign w_rd_nxt   = r_rd_ptr + DEPTH_LOG2'(1);
  assign w_nmi_set  = w_push_ok || ((NMI_REARM != 0) && w_pop_ok && (w_count_nxt != '0));
  assign w_tmr_wrap = (r_tmr == TMR_W'(TIMER_PERIOD - 1));

  always_comb begin
    w_count_nxt = r_count;
    if (w_push_ok && !w_pop_ok)
      w_count_nxt = r_count + CNT_W'(1);
    else if (w_pop_ok && !w_push_ok)
      w_count_nxt = r_count - CNT_W'(1);
  end

  // The new head may be the word being written this cycle, so bypass sndno in those cases.
  always_comb begin
    w_latch_nxt = r_latch;
    if (w_push_ok && (r_count == '0))
      w_latch_nxt = bus.sndno;
    else if (w_pop_ok && w_push_ok && (r_count == CNT_W'(1)))
      w_latch_nxt = bus.sndno;
    else if (w_pop_ok && (r_count > CNT_W'(1)))
      w_latch_nxt = r_mem[w_rd_nxt];
  end

  always_ff @(posedge clk8M) begin
    if (w_push_ok)
      r_mem[r_wr_ptr] <= bus.sndno;
  end

  always_ff @(posedge clk8M or posedge reset) begin
    if (reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_latch   <= '0;
      r_start_d <= 1'b0;
      r_rd_d    <= 1'b0;
      r_nmi     <= 1'b0;
      r_irq     <= 1'b0;
      r_ovf     <= 1'b0;
      r_tmr     <= '0;
    end else begin
      r_start_d <= bus.sndstart;
      r_rd_d    <= bus.com_rd;
      r_count   <= w_count_nxt;
      r_latch   <= w_latch_nxt;
      if (w_push_ok)
        r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
      if (w_pop_ok)
        r_rd_ptr <= w_rd_nxt;

      if (w_nmi_set)
        r_nmi <= 1'b1;
      else if (bus.cpu_nmia)
        r_nmi <= 1'b0;

      if (w_drop)
        r_ovf <= 1'b1;
      else if (bus.ovf_clr)
        r_ovf <= 1'b0;

      if (w_tmr_wrap) begin
        r_tmr <= '0;
        r_irq <= 1'b1;
      end else begin
        r_tmr <= r_tmr + TMR_W'(1);
        if (bus.cpu_irqa)
          r_irq <= 1'b0;
      end
    end
  end

  assign bus.cpu_nmi    = r_nmi;
  assign bus.cpu_irq    = r_irq;
  assign bus.comlatch   = r_latch;
  assign bus.fifo_count = r_count;
  assign bus.overflow   = r_ovf;
endmodule
